// File: rtl/doom_pkg.sv
// Shared definitions for the shared-memory responder: FSM state type and window defaults.
package doom_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        RESP  = 2'd2
    } shmem_state_t;

    localparam logic [31:0] SHMEM_BASE_ADDR = 32'hC000_0000;
    localparam int          SHMEM_DEPTH     = 1024;
    localparam int          SHMEM_CNT_W     = 4;
    localparam logic [15:0] SHMEM_OOB_MAX   = 16'hFFFF;

    // Offset of a byte address into the window; wraps modulo 2^32 so addresses below base land far out.
    function automatic logic [31:0] window_offset(input logic [31:0] addr, input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/shmem_ram.sv
// Single-port DEPTHx8 synchronous RAM with one-cycle read latency; contents are never reset.
module shmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          write_en,
    input  logic [7:0]    write_data,
    input  logic          read_en,
    output logic [7:0]    read_data
);

    logic [7:0] mem [DEPTH];

    // Read data register only moves on an issued read, so it holds the last returned byte.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[addr] <= write_data;
        end
        if (read_en) begin
            read_data <= mem[addr];
        end
    end

endmodule

// File: rtl/shmem_responder.sv
// Memory-mapped byte responder with configurable stall; optional out-of-window
// transfer counter enabled by defining SHMEM_OOB_CNT_EN.
module shmem_responder
    import doom_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = SHMEM_BASE_ADDR,
    parameter int          DEPTH       = SHMEM_DEPTH,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [7:0]  mem_writedata,
    output logic [7:0]  mem_readdata,
    output logic        mem_waitrequest,
    output logic        busy
`ifdef SHMEM_OOB_CNT_EN
    ,
    output logic [15:0] oob_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    shmem_state_t           state;
    logic [SHMEM_CNT_W-1:0] count;
    logic [31:0]            addr_q;
    logic                   op_write;
    logic [7:0]             wdata_q;
    logic                   zero_sel;

    logic [31:0] cur_addr;
    logic [31:0] offset;
    logic        in_window;
    logic [AW-1:0] index;
    logic        req_held;
    logic        read_op;
    logic        start_resp;
    logic        ram_read;
    logic        ram_write;
    logic [7:0]  ram_rdata;

    // In IDLE with no stall the RAM read must be issued from the live address.
    always_comb begin
        cur_addr   = (state == IDLE) ? mem_address : addr_q;
        offset     = window_offset(cur_addr, BASE_ADDR);
        in_window  = offset < 32'(DEPTH);
        index      = offset[AW-1:0];
        req_held   = op_write ? mem_write : mem_read;
        read_op    = (state == IDLE) ? mem_read : !op_write;
        start_resp = 1'b0;
        unique case (state)
            IDLE:    start_resp = (mem_read || mem_write) && (WAIT_CYCLES == 0);
            STALL:   start_resp = req_held && (count == 4'd1);
            default: start_resp = 1'b0;
        endcase
        ram_read  = start_resp && read_op && in_window;
        ram_write = (state == RESP) && op_write && in_window;
    end

    shmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk        (clk),
        .addr       (index),
        .write_en   (ram_write),
        .write_data (wdata_q),
        .read_en    (ram_read),
        .read_data  (ram_rdata)
    );

    // Out-of-window reads and the post-reset value present zero without touching the RAM.
    assign mem_readdata = zero_sel ? 8'h00 : ram_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            count           <= '0;
            addr_q          <= '0;
            op_write        <= 1'b0;
            wdata_q         <= '0;
            zero_sel        <= 1'b1;
            mem_waitrequest <= 1'b1;
            busy            <= 1'b0;
        end else begin
            mem_waitrequest <= 1'b1;
            if (start_resp && read_op) begin
                zero_sel <= !in_window;
            end
            unique case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        addr_q   <= mem_address;
                        op_write <= mem_write && !mem_read;
                        wdata_q  <= mem_writedata;
                        count    <= SHMEM_CNT_W'(WAIT_CYCLES);
                        busy     <= 1'b1;
                        if (start_resp) begin
                            state           <= RESP;
                            mem_waitrequest <= 1'b0;
                        end else begin
                            state <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (!req_held) begin
                        state <= IDLE;
                        count <= '0;
                        busy  <= 1'b0;
                    end else if (count == 4'd1) begin
                        state           <= RESP;
                        count           <= '0;
                        mem_waitrequest <= 1'b0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHMEM_OOB_CNT_EN
    // Counts completed transfers that fell outside the window, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oob_count <= '0;
        end else if (state == RESP && !in_window && oob_count != SHMEM_OOB_MAX) begin
            oob_count <= oob_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shmem_responder.sv
// Directed self-checking bench: one responder with default stall, one with zero stall.
module tb_shmem_responder;

    logic        clk;
    logic        reset;
    logic [31:0] addr_s [2];
    logic [7:0]  wd_s [2];
    logic [1:0]  rd_s;
    logic [1:0]  wr_s;
    logic [7:0]  rdata_s [2];
    logic [1:0]  wait_s;
    logic [1:0]  busy_s;
`ifdef SHMEM_OOB_CNT_EN
    logic [15:0] oob_s [2];
`endif

    int assertCount;
    int failCount;

    shmem_responder dut (
        .clk             (clk),
        .reset           (reset),
        .mem_address     (addr_s[0]),
        .mem_read        (rd_s[0]),
        .mem_write       (wr_s[0]),
        .mem_writedata   (wd_s[0]),
        .mem_readdata    (rdata_s[0]),
        .mem_waitrequest (wait_s[0]),
        .busy            (busy_s[0])
`ifdef SHMEM_OOB_CNT_EN
        ,
        .oob_count       (oob_s[0])
`endif
    );

    shmem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk             (clk),
        .reset           (reset),
        .mem_address     (addr_s[1]),
        .mem_read        (rd_s[1]),
        .mem_write       (wr_s[1]),
        .mem_writedata   (wd_s[1]),
        .mem_readdata    (rdata_s[1]),
        .mem_waitrequest (wait_s[1]),
        .busy            (busy_s[1])
`ifdef SHMEM_OOB_CNT_EN
        ,
        .oob_count       (oob_s[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one transfer and reports the cycle in which waitrequest dropped (-1 on timeout).
    task automatic applyStimulus(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [7:0] d, output int lat, output logic [7:0] data);
        bit done;
        @(negedge clk);
        addr_s[sel] = a;
        wd_s[sel]   = d;
        rd_s[sel]   = rd;
        wr_s[sel]   = wr;
        lat  = -1;
        data = 8'h00;
        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (!wait_s[sel]) begin
                lat  = c;
                data = rdata_s[sel];
                done = 1'b1;
            end
        end
        rd_s[sel] = 1'b0;
        wr_s[sel] = 1'b0;
        @(negedge clk);
    endtask

    task automatic writeByte(input int sel, input logic [31:0] a, input logic [7:0] d, input int expLat, input string tag);
        int lat;
        logic [7:0] data;
        applyStimulus(sel, 1'b0, 1'b1, a, d, lat, data);
        checkOutput(tag, 32'(lat), 32'(expLat));
    endtask

    task automatic readByte(input int sel, input logic [31:0] a, input logic [7:0] expData, input int expLat, input string tag);
        int lat;
        logic [7:0] data;
        applyStimulus(sel, 1'b1, 1'b0, a, 8'h00, lat, data);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_data"}, 32'(data), 32'(expData));
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset = 1'b0;
        rd_s  = '0;
        wr_s  = '0;
        for (int i = 0; i < 2; i++) begin
            addr_s[i] = '0;
            wd_s[i]   = '0;
        end
        repeat (3) @(negedge clk);
        checkOutput("rst_wait", 32'(wait_s[0]), 32'd1);
        checkOutput("rst_busy", 32'(busy_s[0]), 32'd0);
        checkOutput("rst_rdata", 32'(rdata_s[0]), 32'h00);
        checkOutput("rst_wait0", 32'(wait_s[1]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("idle_wait", 32'(wait_s[0]), 32'd1);

        $display("[TB] write/read in-window");
        writeByte(0, 32'hC000_0010, 8'hA5, 3, "wr_a5_lat");
        readByte(0, 32'hC000_0010, 8'hA5, 3, "rd_a5");
        repeat (2) @(negedge clk);
        checkOutput("hold_rdata", 32'(rdata_s[0]), 32'hA5);

        $display("[TB] out-of-window transfers");
        readByte(0, 32'hC000_0400, 8'h00, 3, "rd_oob");
`ifdef SHMEM_OOB_CNT_EN
        checkOutput("oob_cnt1", 32'(oob_s[0]), 32'd1);
`endif
        writeByte(0, 32'hC000_0000, 8'h10, 3, "wr_off0_lat");
        writeByte(0, 32'hC000_0400, 8'h99, 3, "wr_oob_lat");
        readByte(0, 32'hC000_0000, 8'h10, 3, "rd_off0");
        readByte(0, 32'hBFFF_FFFF, 8'h00, 3, "rd_below");
`ifdef SHMEM_OOB_CNT_EN
        checkOutput("oob_cnt3", 32'(oob_s[0]), 32'd3);
`endif

        $display("[TB] aborted write");
        writeByte(0, 32'hC000_0005, 8'h5A, 3, "wr_off5_lat");
        @(negedge clk);
        addr_s[0] = 32'hC000_0005;
        wd_s[0]   = 8'h77;
        wr_s[0]   = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy_stall", 32'(busy_s[0]), 32'd1);
        wr_s[0] = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy_idle", 32'(busy_s[0]), 32'd0);
        checkOutput("abort_wait", 32'(wait_s[0]), 32'd1);
        readByte(0, 32'hC000_0005, 8'h5A, 3, "rd_off5");

        $display("[TB] simultaneous read and write");
        writeByte(0, 32'hC000_0002, 8'h42, 3, "wr_off2_lat");
        begin
            int lat;
            logic [7:0] data;
            applyStimulus(0, 1'b1, 1'b1, 32'hC000_0002, 8'hFF, lat, data);
            checkOutput("rw_lat", 32'(lat), 32'd3);
            checkOutput("rw_data", 32'(data), 32'h42);
        end
        readByte(0, 32'hC000_0002, 8'h42, 3, "rd_off2");

        $display("[TB] zero-stall instance");
        writeByte(1, 32'hC000_0020, 8'h3C, 1, "w0_wr_lat");
        readByte(1, 32'hC000_0020, 8'h3C, 1, "w0_rd");
        @(negedge clk);
        addr_s[1] = 32'hC000_0020;
        rd_s[1]   = 1'b1;
        @(negedge clk);
        checkOutput("b2b_resp1", 32'(wait_s[1]), 32'd0);
        @(negedge clk);
        checkOutput("b2b_idle", 32'(wait_s[1]), 32'd1);
        @(negedge clk);
        checkOutput("b2b_resp2", 32'(wait_s[1]), 32'd0);
        rd_s[1] = 1'b0;
        @(negedge clk);

        $display("[TB] reset during stall");
        writeByte(0, 32'hC000_0007, 8'h22, 3, "wr_off7_lat");
        @(negedge clk);
        addr_s[0] = 32'hC000_0007;
        wd_s[0]   = 8'h11;
        wr_s[0]   = 1'b1;
        @(negedge clk);
        checkOutput("mid_busy", 32'(busy_s[0]), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_wait", 32'(wait_s[0]), 32'd1);
        checkOutput("mid_rst_busy", 32'(busy_s[0]), 32'd0);
        checkOutput("mid_rst_rdata", 32'(rdata_s[0]), 32'h00);
`ifdef SHMEM_OOB_CNT_EN
        checkOutput("mid_rst_oob", 32'(oob_s[0]), 32'd0);
`endif
        wr_s[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        readByte(0, 32'hC000_0007, 8'h22, 3, "rd_off7");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
